// File: rtl/systolic_pkg.sv
// systolic_pkg: shared definitions for the convolution datapath.
//   - default geometry of the systolic array (M result rows, K filter lanes)
//   - word-address bases of the shared memory regions
//   - writeback FSM state encoding
//   - cnt_w(): counter width helper, never narrower than one bit
package systolic_pkg;

  localparam int M_DEF          = 12;
  localparam int K_DEF          = 5;
  localparam int DATA_WIDTH_DEF = 32;
  localparam int ADDR_WIDTH_DEF = 32;

  localparam logic [31:0] IMG_BASE    = 32'h0000_0000;
  localparam logic [31:0] WEIGHT_BASE = 32'h0000_1000;
  localparam logic [31:0] IM2COL_BASE = 32'h0000_2000;
  localparam logic [31:0] OUTPUT_BASE = 32'h0000_3000;

  localparam logic [1:0] CAPTURE = 2'd0;
  localparam logic [1:0] DRAIN   = 2'd1;
  localparam logic [1:0] DONE    = 2'd2;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/systolic_writeback_row_buffer.sv
// wb_row_buffer: holds the M result rows of one convolution pass.
// Ports:
//   clk      clock
//   we       write enable; wr_row is stored into entry wr_idx on the rising edge
//   wr_idx   row index being written
//   wr_row   full result row, K lanes of DATA_WIDTH
//   rd_idx   row index being read
//   rd_lane  lane within the row being read
//   rd_data  selected lane, combinational
// Contents are deliberately not reset; every entry is rewritten before it is read.
module wb_row_buffer
  import systolic_pkg::*;
#(
  parameter int M          = M_DEF,
  parameter int K          = K_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int IDX_W      = cnt_w(M),
  parameter int LANE_W     = cnt_w(K)
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [IDX_W-1:0]        wr_idx,
  input  logic [DATA_WIDTH*K-1:0] wr_row,
  input  logic [IDX_W-1:0]        rd_idx,
  input  logic [LANE_W-1:0]       rd_lane,
  output logic [DATA_WIDTH-1:0]   rd_data
);

  logic [DATA_WIDTH*K-1:0] mem [M];
  logic [DATA_WIDTH*K-1:0] rd_row;

  always_ff @(posedge clk) begin
    if (we) mem[wr_idx] <= wr_row;
  end

  always_comb begin
    rd_row  = mem[rd_idx];
    rd_data = '0;
    for (int i = 0; i < K; i++) begin
      if (rd_lane == LANE_W'(i)) rd_data = rd_row[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

endmodule

// File: rtl/systolic_writeback.sv
// systolic_writeback: captures the M result rows emitted by the systolic array
// and commits them to shared memory in filter-major order, one word per cycle,
// at OUTPUT_BASE + k*M + m.
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   Y          result row, lane k at Y[(k+1)*DATA_WIDTH-1 : k*DATA_WIDTH]
//   valid      Y carries a valid row this cycle
//   addr_wr    memory write address (registered)
//   data_wr    memory write data (registered)
//   mem_wr_en  write strobe, one word per asserted cycle (registered)
//   done       all K*M words written; held until rst (registered)
// Compile-time option: SYSTOLIC_WB_RELU_EN applies a signed ReLU to every
// written word in the output register stage (no added latency).
module systolic_writeback #(
  parameter int                    M           = systolic_pkg::M_DEF,
  parameter int                    K           = systolic_pkg::K_DEF,
  parameter int                    DATA_WIDTH  = systolic_pkg::DATA_WIDTH_DEF,
  parameter int                    ADDR_WIDTH  = systolic_pkg::ADDR_WIDTH_DEF,
  parameter logic [ADDR_WIDTH-1:0] OUTPUT_BASE = ADDR_WIDTH'(systolic_pkg::OUTPUT_BASE)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH*K-1:0] Y,
  input  logic                    valid,
  output logic [ADDR_WIDTH-1:0]   addr_wr,
  output logic [DATA_WIDTH-1:0]   data_wr,
  output logic                    mem_wr_en,
  output logic                    done
);

  import systolic_pkg::*;

  localparam int RW = cnt_w(M);
  localparam int LW = cnt_w(K);
  localparam logic [RW-1:0] M_LAST = RW'(M - 1);
  localparam logic [LW-1:0] K_LAST = LW'(K - 1);

  logic [1:0]            state;
  logic [RW-1:0]         row_cnt;
  logic [RW-1:0]         m;
  logic [LW-1:0]         k;
  logic                  buf_we;
  logic [DATA_WIDTH-1:0] lane;
  logic [DATA_WIDTH-1:0] out_word;
  logic [ADDR_WIDTH-1:0] wr_addr;

`ifdef SYSTOLIC_WB_RELU_EN
  function automatic logic [DATA_WIDTH-1:0] relu(input logic signed [DATA_WIDTH-1:0] x);
    return (x < 0) ? '0 : x;
  endfunction
  assign out_word = relu(lane);
`else
  assign out_word = lane;
`endif

  // Rows past the M-th are dropped: the buffer is only written in CAPTURE.
  assign buf_we = (state == CAPTURE) && valid;

  wb_row_buffer #(
    .M          (M),
    .K          (K),
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_W      (RW),
    .LANE_W     (LW)
  ) u_row_buffer (
    .clk     (clk),
    .we      (buf_we),
    .wr_idx  (row_cnt),
    .wr_row  (Y),
    .rd_idx  (m),
    .rd_lane (k),
    .rd_data (lane)
  );

  // Filter-major layout: all M pixels of filter k are contiguous.
  assign wr_addr = OUTPUT_BASE + ADDR_WIDTH'(k) * ADDR_WIDTH'(M) + ADDR_WIDTH'(m);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= CAPTURE;
      row_cnt   <= '0;
      m         <= '0;
      k         <= '0;
      addr_wr   <= '0;
      data_wr   <= '0;
      mem_wr_en <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        CAPTURE: begin
          mem_wr_en <= 1'b0;
          if (valid) begin
            if (row_cnt == M_LAST) begin
              state   <= DRAIN;
              row_cnt <= '0;
              m       <= '0;
              k       <= '0;
            end else begin
              row_cnt <= row_cnt + RW'(1);
            end
          end
        end
        DRAIN: begin
          addr_wr   <= wr_addr;
          data_wr   <= out_word;
          mem_wr_en <= 1'b1;
          if (m == M_LAST) begin
            m <= '0;
            if (k == K_LAST) state <= DONE;
            else             k     <= k + LW'(1);
          end else begin
            m <= m + RW'(1);
          end
        end
        DONE: begin
          mem_wr_en <= 1'b0;
          done      <= 1'b1;
        end
        default: state <= CAPTURE;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_writeback.sv
module tb_systolic_writeback;

  localparam int M  = 12;
  localparam int K  = 5;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam logic [31:0] BASE = 32'h0000_3000;

  logic              clk = 1'b0;
  logic              rst;
  logic [DW*K-1:0]   Y;
  logic              valid;
  logic [AW-1:0]     addr_wr;
  logic [DW-1:0]     data_wr;
  logic              mem_wr_en;
  logic              done;

  systolic_writeback #(
    .M(M), .K(K), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OUTPUT_BASE(BASE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .Y         (Y),
    .valid     (valid),
    .addr_wr   (addr_wr),
    .data_wr   (data_wr),
    .mem_wr_en (mem_wr_en),
    .done      (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Write log gathered by the monitor, #1 after each rising edge.
  logic [31:0] wa [$];
  logic [31:0] wd [$];
  int          wc [$];
  int          done_rises = 0;
  int          done_cyc   = -1;
  logic        done_q     = 1'b0;

  always @(posedge clk) begin
    #1;
    if (mem_wr_en === 1'b1) begin
      wa.push_back(addr_wr);
      wd.push_back(data_wr);
      wc.push_back(cyc);
    end
    if (done === 1'b1 && done_q !== 1'b1) begin
      done_rises++;
      done_cyc = cyc;
    end
    done_q = done;
  end

  // Reference: rows the model expects to be committed, and the edge that
  // captured the M-th valid row.
  logic [31:0] rows [M][K];
  int          cap_edge;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_word(input logic [31:0] v);
`ifdef SYSTOLIC_WB_RELU_EN
    return ($signed(v) < 0) ? 32'd0 : v;
`else
    return v;
`endif
  endfunction

  task automatic clear_mon();
    wa.delete();
    wd.delete();
    wc.delete();
    done_rises = 0;
    done_cyc   = -1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst   = 1'b1;
    valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear_mon();
  endtask

  // gap_mode: 0 back-to-back, 1 alternating 1/0, 2 random gaps.
  // pat: 0 spec pattern (m<<8)|k, 1 random data, 2 spec pattern with ReLU probes.
  // Rows beyond the M-th carry 0xDEAD in every lane.
  task automatic drive(input int gap_mode, input int n_valid, input int pat);
    int got = 0;
    int slot = 0;
    logic v;
    logic [DW*K-1:0] yv;
    logic [31:0] w;
    while (got < n_valid) begin
      @(negedge clk);
      case (gap_mode)
        1:       v = (slot % 2 == 0);
        2:       v = 1'($urandom_range(0, 1));
        default: v = 1'b1;
      endcase
      slot++;
      if (v) begin
        for (int kk = 0; kk < K; kk++) begin
          if (got >= M)      w = 32'h0000_DEAD;
          else if (pat == 1) w = $urandom;
          else               w = (got << 8) | kk;
          if (pat == 2 && got == 0 && kk == 0) w = 32'hFFFF_FFF6;
          if (pat == 2 && got == 0 && kk == 1) w = 32'h7FFF_FFFF;
          yv[kk*DW +: DW] = w;
          if (got < M) rows[got][kk] = w;
        end
        if (got == M - 1) cap_edge = cyc + 1;
        got++;
        valid = 1'b1;
        Y     = yv;
      end else begin
        for (int kk = 0; kk < K; kk++) yv[kk*DW +: DW] = $urandom;
        valid = 1'b0;
        Y     = yv;
      end
    end
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 300 && done !== 1'b1; i++) @(negedge clk);
    chk($sformatf("%s_done_seen", tag), 64'(done), 64'd1);
  endtask

  task automatic check_run(input string tag);
    int n;
    chk($sformatf("%s_write_count", tag), 64'(wa.size()), 64'(M*K));
    n = (wa.size() < M*K) ? wa.size() : M*K;
    for (int i = 0; i < n; i++) begin
      int fk = i / M;
      int fm = i % M;
      chk($sformatf("%s_addr[%0d]", tag, i), 64'(wa[i]), 64'(BASE + 32'(fk*M + fm)));
      chk($sformatf("%s_data[%0d]", tag, i), 64'(wd[i]), 64'(model_word(rows[fm][fk])));
      chk($sformatf("%s_cycle[%0d]", tag, i), 64'(wc[i]), 64'(cap_edge + 1 + i));
    end
    chk($sformatf("%s_done_cycle", tag), 64'(done_cyc), 64'(cap_edge + 1 + M*K));
    chk($sformatf("%s_done_rises", tag), 64'(done_rises), 64'd1);
  endtask

  initial begin
    int dead;
    rst   = 1'b1;
    valid = 1'b0;
    Y     = '0;

    // Reset state
    @(negedge clk);
    chk("rst_mem_wr_en", 64'(mem_wr_en), 64'd0);
    chk("rst_addr_wr",   64'(addr_wr),   64'd0);
    chk("rst_data_wr",   64'(data_wr),   64'd0);
    chk("rst_done",      64'(done),      64'd0);
    rst = 1'b0;

    // Basic back-to-back run with the spec pattern
    do_reset();
    drive(0, M, 0);
    wait_done("basic");
    check_run("basic");
    if (wa.size() == M*K) begin
      chk("basic_first_addr", 64'(wa[0]),  64'h3000);
      chk("basic_first_data", 64'(wd[0]),  64'h0);
      chk("basic_k1m0_addr",  64'(wa[12]), 64'h300C);
      chk("basic_k1m0_data",  64'(wd[12]), 64'h001);
      chk("basic_last_addr",  64'(wa[59]), 64'h303B);
      chk("basic_last_data",  64'(wd[59]), 64'h0B04);
    end

    // Idle hold: valid ignored after done
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      valid = 1'b1;
      Y     = {$urandom, $urandom, $urandom, $urandom, $urandom};
      chk($sformatf("idle_mem_wr_en[%0d]", i), 64'(mem_wr_en), 64'd0);
      chk($sformatf("idle_done[%0d]", i),      64'(done),      64'd1);
    end
    @(negedge clk);
    valid = 1'b0;
    chk("idle_write_count", 64'(wa.size()), 64'(M*K));

    // Alternating gaps
    do_reset();
    drive(1, M, 1);
    wait_done("gap_alt");
    check_run("gap_alt");

    // Random gaps
    do_reset();
    drive(2, M, 1);
    wait_done("gap_rand");
    check_run("gap_rand");

    // Overrun: two extra rows must never reach memory
    do_reset();
    drive(0, M + 2, 1);
    wait_done("overrun");
    repeat (5) @(negedge clk);
    check_run("overrun");
    dead = 0;
    foreach (wd[i]) if (wd[i] == 32'h0000_DEAD) dead++;
    chk("overrun_dead_words", 64'(dead), 64'd0);

    // Reset mid-capture, then a clean run must start from row 0
    do_reset();
    drive(0, 5, 1);
    do_reset();
    drive(0, M, 1);
    wait_done("rst_capture");
    check_run("rst_capture");

    // Reset mid-drain
    do_reset();
    drive(0, M, 1);
    for (int i = 0; i < 200 && wa.size() < 20; i++) @(negedge clk);
    chk("drain_reached_20", 64'(wa.size() >= 20), 64'd1);
    rst = 1'b1;
    #1;
    chk("rst_drain_mem_wr_en", 64'(mem_wr_en), 64'd0);
    chk("rst_drain_addr_wr",   64'(addr_wr),   64'd0);
    chk("rst_drain_data_wr",   64'(data_wr),   64'd0);
    chk("rst_drain_done",      64'(done),      64'd0);
    @(negedge clk);
    rst = 1'b0;
    clear_mon();
    drive(0, M, 1);
    wait_done("after_rst");
    check_run("after_rst");

    // ReLU probes
    do_reset();
    drive(0, M, 2);
    wait_done("relu");
    check_run("relu");
    if (wa.size() == M*K) begin
`ifdef SYSTOLIC_WB_RELU_EN
      chk("relu_neg_word", 64'(wd[0]),  64'h0000_0000);
      chk("relu_pos_word", 64'(wd[12]), 64'h7FFF_FFFF);
`else
      chk("relu_neg_word", 64'(wd[0]),  64'hFFFF_FFF6);
      chk("relu_pos_word", 64'(wd[12]), 64'h7FFF_FFFF);
`endif
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
